// File: rtl/up_counter.sv
// Free-running Size-bit binary up-counter that wraps to zero after its maximum value.
// An asynchronous active-low reset clears it, and at_max flags the last value of each period.
module up_counter #(
   parameter int Size = 5
) (
   input  logic            clock,
   input  logic            reset,
   output logic [Size-1:0] count,
   output logic            at_max
);

   localparam logic [Size-1:0] MaxValue = '1;

   logic [Size-1:0] cnt;

   // The clear is asynchronous, so count drops to 0 mid-cycle without waiting for a clock edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + Size'(1);
      end
   end

   assign count  = cnt;
   assign at_max = (cnt == MaxValue);

endmodule

// File: tb/tb_up_counter.sv
// Directed testbench for up_counter: a 5-bit and a 3-bit instance are checked
// against hand-computed values, sampled on the falling clock edge.
module tb_up_counter;

   logic       clock;
   logic       reset;
   logic       reset3;
   logic [4:0] count;
   logic       at_max;
   logic [2:0] count3;
   logic       at_max3;

   int total = 0;
   int bad   = 0;

   up_counter #(.Size(5)) dut (
      .clock  (clock),
      .reset  (reset),
      .count  (count),
      .at_max (at_max)
   );

   up_counter #(.Size(3)) dut3 (
      .clock  (clock),
      .reset  (reset3),
      .count  (count3),
      .at_max (at_max3)
   );

   // Period of 10 time units, with rising edges at 5, 15, 25, and so on.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Waits for n falling edges. Starting from a falling edge, this spans exactly n rising edges.
   task automatic applyStimulus(input int n);
      repeat (n) @(negedge clock);
   endtask

   initial begin
      reset  = 1'b1;
      reset3 = 1'b1;
      #1;
      reset  = 1'b0;
      reset3 = 1'b0;

      // While reset is held low, clock edges must have no effect.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1);
         checkOutput("powerup_count", 32'(count), 0);
         checkOutput("powerup_at_max", 32'(at_max), 0);
      end

      // Release reset between edges, then count edges.
      reset = 1'b1;
      applyStimulus(1);
      checkOutput("first_edge", 32'(count), 1);
      applyStimulus(9);
      checkOutput("ten_edges", 32'(count), 10);
      checkOutput("ten_at_max", 32'(at_max), 0);
      applyStimulus(21);
      checkOutput("edge31_count", 32'(count), 31);
      checkOutput("edge31_at_max", 32'(at_max), 1);
      applyStimulus(1);
      checkOutput("edge32_wrap", 32'(count), 0);
      checkOutput("edge32_at_max", 32'(at_max), 0);
      applyStimulus(1);
      checkOutput("edge33_count", 32'(count), 1);

      // Assert reset mid-cycle at count 17.
      applyStimulus(16);
      checkOutput("reach17", 32'(count), 17);
      reset = 1'b0;
      #1;
      checkOutput("async_clear", 32'(count), 0);
      checkOutput("async_at_max", 32'(at_max), 0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1);
         checkOutput("hold_in_reset", 32'(count), 0);
      end
      reset = 1'b1;
      applyStimulus(1);
      checkOutput("after_release", 32'(count), 1);

      // Short reset glitch with no rising edge inside it.
      applyStimulus(2);
      checkOutput("before_glitch", 32'(count), 3);
      #1;
      reset = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      checkOutput("glitch_clear", 32'(count), 0);
      applyStimulus(1);
      checkOutput("after_glitch", 32'(count), 1);

      // The 3-bit instance sat in reset this whole time. Release it and walk one full period.
      checkOutput("size3_reset", 32'(count3), 0);
      checkOutput("size3_reset_at_max", 32'(at_max3), 0);
      reset3 = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(1);
         checkOutput("size3_count", 32'(count3), 32'(i % 8));
         checkOutput("size3_at_max", 32'(at_max3), (i == 7) ? 32'd1 : 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/up_counter.md
# up_counter

Free-running binary up-counter with a parameterized width. It advances by one on every rising clock edge and wraps to zero after its maximum value. An asynchronous active-low reset clears it. It is a leaf block with no handshake, suitable as a cycle counter or a timebase source.

## Interface

Parameters:
- Size, default 5, width of the counter in bits; legal range 1..32.

Ports:
- clock  input  1     rising-edge clock; the only clock domain.
- reset  input  1     asynchronous, active-low reset; 0 clears the counter.
- count  output Size  current counter value, driven directly from a register.
- at_max output 1     high while count equals 2^Size-1; may be left unconnected.

## Operation

- Single Size-bit register, cnt, drives count.
- reset low: cnt is forced to 0 immediately.
  - No clock edge is required.
  - The clear holds for as long as reset stays low.
- reset high, each rising clock edge: cnt <= cnt + 1, modulo 2^Size.
- Wrap-around: 2^Size-1 is followed by 0. No saturation and no sticky overflow flag.
- at_max is purely combinational: (cnt == 2^Size-1).
  - During reset it is 0, because cnt is 0.
  - For Size=1 it equals count.
- No enable, load or direction control. The counter always counts while out of reset.
- No X propagation after reset: every register bit has a defined reset value.
- Outputs at reset: count = 0, at_max = 0.

## Timing

- Latency: count changes one clock-to-q after each rising edge. Consumers sample after the edge, e.g. 1 time unit later.
- Reset assertion (falling edge of reset): count goes to 0 asynchronously, mid-cycle, regardless of clock.
- Reset deassertion:
  - The first rising edge at which reset is already high increments 0 -> 1.
  - An edge coincident with the release is treated as still in reset, so count stays 0.
- Steady state: count after N counting edges = N mod 2^Size.
- Period: 2^Size clock cycles, i.e. 32 cycles for Size=5.
- at_max is high for exactly one cycle per period, in the cycle before wrap.

## Test plan

- Power-up with reset=0, clock toggling -> count=0 and at_max=0 on every sample; clock edges have no effect.
- Release reset, then 1 rising edge -> count=1; after 10 edges -> count=10 (Size=5).
- Run 31 edges from reset -> count=31 and at_max=1. Edge 32 -> count=0 and at_max=0. Edge 33 -> count=1.
- At count=17, drive reset=0 halfway between edges -> count=0 before the next edge. Hold for 3 edges -> count stays 0. Release, then 1 edge -> count=1.
- Assert reset=0 for a glitch shorter than a clock period, with no edge inside it -> count=0 after the glitch. The next edge after release gives count=1.
- Size=3 instance: from reset, 8 edges -> count sequence 1,2,...,7,0; at_max=1 only when count=7.
